// File: rtl/dpram_fifo_ctrl_if.sv
// Stream and RAM-side signal bundle for dpram_fifo_ctrl.
// slave: the controller side. master: the parent/RAM/stream side.
interface dpram_fifo_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  ram_we1;
  logic [ADDR_WIDTH-1:0] ram_addr1;
  logic [DATA_WIDTH-1:0] ram_data1;
  logic                  ram_we2;
  logic [ADDR_WIDTH-1:0] ram_addr2;
  logic [DATA_WIDTH-1:0] ram_data2;
  logic [DATA_WIDTH-1:0] ram_out2;

  modport slave (
    input  in_valid, in_data, out_ready, ram_out2,
    output in_ready, out_valid, out_data,
           ram_we1, ram_addr1, ram_data1, ram_we2, ram_addr2, ram_data2
  );

  modport master (
    output in_valid, in_data, out_ready, ram_out2,
    input  in_ready, out_valid, out_data,
           ram_we1, ram_addr1, ram_data1, ram_we2, ram_addr2, ram_data2
  );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller in front of a dual-port RAM (port 1 writes, port 2 reads).
// A 2-entry output buffer absorbs the RAM's 1-cycle registered read latency,
// giving DEPTH+2 words of capacity and 1 word/cycle sustained throughput.
// Optional: define DPRAM_FIFO_LEVEL_EN to add a registered 'level' output.
module dpram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  dpram_fifo_ctrl_if.slave      bus
`ifdef DPRAM_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH+1:0] level
`endif
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  logic [PW-1:0]                   wr_ptr, rd_ptr, ram_cnt;
  logic                            rd_pend;
  logic [1:0][DATA_WIDTH-1:0]      ob;
  logic [1:0]                      ob_cnt;
  logic                            in_ready, push, pop, issue, out_valid;
  logic [2:0]                      ob_need, ob_room;

  assign ram_cnt   = wr_ptr - rd_ptr;
  assign in_ready  = (ram_cnt != PW'(DEPTH)) && !clr;
  // No RAM write is ever issued while reset is held, even if in_valid is high.
  assign push      = bus.in_valid && in_ready && rst_n;
  assign out_valid = (ob_cnt != 2'd0);
  assign pop       = out_valid && bus.out_ready;

  // Only issue a read if the word it returns next cycle is guaranteed a slot.
  assign ob_need   = {1'b0, ob_cnt} + {2'b00, rd_pend};
  assign ob_room   = 3'd2 + {2'b00, pop};
  assign issue     = (ram_cnt != '0) && (ob_need < ob_room) && !clr;

  assign bus.in_ready  = in_ready;
  assign bus.ram_we1   = push;
  assign bus.ram_addr1 = wr_ptr[ADDR_WIDTH-1:0];
  assign bus.ram_data1 = bus.in_data;
  assign bus.ram_we2   = 1'b0;
  assign bus.ram_addr2 = rd_ptr[ADDR_WIDTH-1:0];
  assign bus.ram_data2 = '0;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = ob[0];

  // Pointer and read-pending state; clr flushes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_pend <= 1'b0;
    end else if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_pend <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PW'(1);
      if (issue) rd_ptr <= rd_ptr + PW'(1);
      rd_pend <= issue;
    end
  end

  // Output buffer: ob[0] is the head; capture appends behind any survivor of a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ob     <= '0;
      ob_cnt <= 2'd0;
    end else if (clr) begin
      ob     <= '0;
      ob_cnt <= 2'd0;
    end else begin
      case ({pop, rd_pend})
        2'b10: begin
          ob[0]  <= ob[1];
          ob_cnt <= ob_cnt - 2'd1;
        end
        2'b01: begin
          ob[ob_cnt[0]] <= bus.ram_out2;
          ob_cnt        <= ob_cnt + 2'd1;
        end
        2'b11: begin
          if (ob_cnt == 2'd2) begin
            ob[0] <= ob[1];
            ob[1] <= bus.ram_out2;
          end else begin
            ob[0] <= bus.ram_out2;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DPRAM_FIFO_LEVEL_EN
  localparam int LW = ADDR_WIDTH + 2;
  // Total words held only changes by push/pop; internal moves keep it constant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   level <= '0;
    else if (clr) level <= '0;
    else          level <= level + LW'(push) - LW'(pop);
  end
`endif
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl with ADDR_WIDTH=2 (DEPTH=4) and a
// behavioural dual-port RAM with registered port-2 read data.
module tb_dpram_fifo_ctrl;
  localparam int AW = 2;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  dpram_fifo_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef DPRAM_FIFO_LEVEL_EN
  logic [AW+1:0] level;
`endif

  dpram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
`ifdef DPRAM_FIFO_LEVEL_EN
    ,
    .level (level)
`endif
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write on port 1, registered read on port 2.
  always @(posedge clk) begin
    if (bus.ram_we1) mem[bus.ram_addr1] <= bus.ram_data1;
    bus.ram_out2 <= mem[bus.ram_addr2];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    #12;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", bus.out_data); end
    checks++; if (bus.ram_we1 !== 1'b0) begin errors++; $display("FAIL reset_ram_we1 got %0b exp 0", bus.ram_we1); end
    checks++; if (bus.ram_addr1 !== 2'd0 || bus.ram_addr2 !== 2'd0) begin errors++; $display("FAIL reset_addr got %0d/%0d exp 0/0", bus.ram_addr1, bus.ram_addr2); end
    checks++; if (bus.ram_we2 !== 1'b0 || bus.ram_data2 !== 8'h00) begin errors++; $display("FAIL reset_port2_ties got %0b/%h exp 0/00", bus.ram_we2, bus.ram_data2); end
    rst_n = 1'b1;
    tick();
  endtask

  // Push 0x11..0x16 with out_ready low: 4 words in RAM plus 2 in the buffer.
  task automatic test_fill();
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.in_data = 8'h11 + 8'(i);
      #1;
      checks++; if (bus.in_ready !== 1'b1 || bus.ram_we1 !== 1'b1) begin errors++; $display("FAIL fill_accept[%0d] got rdy=%0b we=%0b exp 1/1", i, bus.in_ready, bus.ram_we1); end
      checks++; if (bus.ram_addr1 !== 2'(i)) begin errors++; $display("FAIL fill_addr1[%0d] got %0d exp %0d", i, bus.ram_addr1, i % 4); end
      tick();
    end
    bus.in_data = 8'h17;
    #1;
    checks++; if (bus.in_ready !== 1'b0 || bus.ram_we1 !== 1'b0) begin errors++; $display("FAIL full_block got rdy=%0b we=%0b exp 0/0", bus.in_ready, bus.ram_we1); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11) begin errors++; $display("FAIL full_head got v=%0b d=%h exp 1/11", bus.out_valid, bus.out_data); end
`ifdef DPRAM_FIFO_LEVEL_EN
    checks++; if (level !== 4'd6) begin errors++; $display("FAIL full_level got %0d exp 6", level); end
`endif
    tick();
    checks++; if (bus.in_ready !== 1'b0 || bus.out_data !== 8'h11) begin errors++; $display("FAIL full_hold got rdy=%0b d=%h exp 0/11", bus.in_ready, bus.out_data); end
  endtask

  // Drain the full controller with out_ready high.
  task automatic test_drain();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      #1;
      if (k == 0) begin
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL drain_rdy0 got %0b exp 0", bus.in_ready); end
      end
      if (k == 1) begin
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL drain_rdy1 got %0b exp 1", bus.in_ready); end
      end
      if (k < 6) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11 + 8'(k)) begin errors++; $display("FAIL drain_word[%0d] got v=%0b d=%h exp 1/%h", k, bus.out_valid, bus.out_data, 8'h11 + 8'(k)); end
      end else begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %0b exp 0", bus.out_valid); end
      end
      tick();
    end
  endtask

  // Single push into an empty controller: out_valid appears 3 cycles later.
  task automatic test_latency();
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hA5;
    tick();
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      if (k == 3) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin errors++; $display("FAIL lat_T+3 got v=%0b d=%h exp 1/a5", bus.out_valid, bus.out_data); end
      end else begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lat_T+%0d got v=%0b exp 0", k, bus.out_valid); end
      end
      tick();
    end
  endtask

  // 40 words with out_ready pattern 1,1,0; pointers wrap several times.
  task automatic test_stream();
    int sent = 0;
    int rcv = 0;
    for (int c = 0; c < 400 && rcv < 40; c++) begin
      bus.in_valid  = (sent < 40);
      bus.in_data   = 8'(sent);
      bus.out_ready = ((c % 3) != 2);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        checks++; if (bus.out_data !== 8'(rcv)) begin errors++; $display("FAIL stream_word[%0d] got %h exp %h", rcv, bus.out_data, 8'(rcv)); end
        rcv++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    checks++; if (rcv != 40) begin errors++; $display("FAIL stream_count got %0d exp 40 (cycle budget)", rcv); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_empty got %0b exp 0", bus.out_valid); end
`ifdef DPRAM_FIFO_LEVEL_EN
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL stream_level got %0d exp 0", level); end
`endif
    tick();
  endtask

  // Flush while a RAM read is in flight; the flushed word must not reappear.
  task automatic test_clr();
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.in_data = 8'h20 + 8'(i);
      tick();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h20) begin errors++; $display("FAIL clr_prepop got v=%0b d=%h exp 1/20", bus.out_valid, bus.out_data); end
    tick();
    bus.out_ready = 1'b0; clr = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h99;
    #1;
    checks++; if (bus.ram_we1 !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL clr_cycle got we=%0b rdy=%0b exp 0/0", bus.ram_we1, bus.in_ready); end
    tick();
    clr = 1'b0; bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL clr_after got v=%0b rdy=%0b exp 0/1", bus.out_valid, bus.in_ready); end
    checks++; if (bus.ram_addr1 !== 2'd0 || bus.ram_addr2 !== 2'd0) begin errors++; $display("FAIL clr_ptrs got %0d/%0d exp 0/0", bus.ram_addr1, bus.ram_addr2); end
`ifdef DPRAM_FIFO_LEVEL_EN
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL clr_level got %0d exp 0", level); end
`endif
    bus.in_valid = 1'b1; bus.in_data = 8'h3C;
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL clr_stale got v=%0b d=%h exp 0", bus.out_valid, bus.out_data); end
    tick();
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C) begin errors++; $display("FAIL clr_first got v=%0b d=%h exp 1/3c", bus.out_valid, bus.out_data); end
    tick();
  endtask

  // Asynchronous reset between clock edges in the middle of a stream.
  task automatic test_async_reset();
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = 8'h50 + 8'(i);
      tick();
    end
    #1;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre got v=%0b exp 1", bus.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.ram_we1 !== 1'b0) begin errors++; $display("FAIL arst_now got v=%0b we=%0b exp 0/0", bus.out_valid, bus.ram_we1); end
    checks++; if (bus.in_ready !== 1'b1 || bus.ram_addr2 !== 2'd0) begin errors++; $display("FAIL arst_state got rdy=%0b a2=%0d exp 1/0", bus.in_ready, bus.ram_addr2); end
    bus.in_valid = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    bus.in_valid = 1'b1; bus.in_data = 8'h77;
    tick();
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      if (k == 3) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h77) begin errors++; $display("FAIL arst_first got v=%0b d=%h exp 1/77", bus.out_valid, bus.out_data); end
      end else begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_T+%0d got v=%0b exp 0", k, bus.out_valid); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_latency();
    test_stream();
    test_clr();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dpram_fifo_ctrl.md
Name: dpram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sits directly upstream of a dual_port_ram instance: port 1 is the write port, port 2 is the read port.
- Accepts a valid/ready stream, generates RAM write and read addresses, and absorbs the RAM's 1-cycle registered read latency with a 2-entry output buffer.
- Presents a valid/ready stream downstream; the parent instantiates the RAM with matching ADDR_WIDTH/DATA_WIDTH.

Parameters:
ADDR_WIDTH, 4, RAM address width; RAM depth DEPTH = 1<<ADDR_WIDTH; must be >= 2
DATA_WIDTH, 8, word width; must equal the RAM DATA_WIDTH

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous flush, active high
in_valid  input  1  upstream word valid
in_ready  output  1  controller can accept a word
in_data  input  DATA_WIDTH  upstream word
out_valid  output  1  downstream word valid
out_ready  input  1  downstream accepts
out_data  output  DATA_WIDTH  downstream word
ram_we1  output  1  RAM port-1 write enable
ram_addr1  output  ADDR_WIDTH  RAM port-1 address
ram_data1  output  DATA_WIDTH  RAM port-1 write data
ram_we2  output  1  RAM port-2 write enable; tied 0
ram_addr2  output  ADDR_WIDTH  RAM port-2 address
ram_data2  output  DATA_WIDTH  tied 0
ram_out2  input  DATA_WIDTH  RAM port-2 registered read data

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- State:
  - wr_ptr and rd_ptr, each ADDR_WIDTH+1 bits.
  - ram_cnt = wr_ptr - rd_ptr (mod 2^(ADDR_WIDTH+1)).
  - rd_pend: 1-bit flag, "read issued last cycle".
  - ob: 2-entry output buffer (ob_cnt 0..2), in-order.
- Reset (rst_n low, asynchronous): pointers 0, rd_pend 0, ob_cnt 0, out_valid 0, out_data 0. Outputs at reset: in_ready 1, ram_we1 0, ram_addr1 0, ram_addr2 0.
- Write port (combinational):
  - in_ready = (ram_cnt != DEPTH) && !clr.
  - push = in_valid && in_ready.
  - ram_we1 = push; ram_addr1 = wr_ptr[ADDR_WIDTH-1:0]; ram_data1 = in_data.
  - wr_ptr increments on push.
- Read issue:
  - ram_addr2 = rd_ptr[ADDR_WIDTH-1:0] at all times.
  - pop = out_valid && out_ready.
  - issue = (ram_cnt != 0) && (ob_cnt + rd_pend - pop < 2) && !clr. ram_cnt comes from registered pointers, so a word pushed in cycle T is first issuable in T+1.
  - On issue: rd_ptr increments; rd_pend <= 1, else 0.
- Capture: when rd_pend is 1, ram_out2 is appended to ob at the clock edge ending that cycle.
- Output stage:
  - out_valid = (ob_cnt != 0); out_data = head of ob.
  - Pop and capture in the same cycle are both honoured; order is preserved.
  - out_data is held stable while out_valid && !out_ready.
- Latency: into an empty controller, a push in cycle T gives out_valid in cycle T+3.
- Throughput: sustained 1 word/cycle with out_ready held high.
- Capacity: DEPTH + 2 words total (DEPTH in RAM plus 2 in ob).
- Boundary conditions:
  - Full (ram_cnt == DEPTH): in_ready 0; no RAM write is generated.
  - Empty: no issue; out_valid 0.
  - Pointer wrap: modulo 2^(ADDR_WIDTH+1); the address uses the low ADDR_WIDTH bits.
  - Same-address read/write in one cycle cannot occur (issue requires ram_cnt != 0, write requires not full).
  - Simultaneous push and issue at ram_cnt == DEPTH-1 or 1: both proceed; ram_cnt is unchanged.
  - clr: next cycle pointers 0, rd_pend 0, ob_cnt 0. Any in-flight ram_out2 is discarded. No push and no issue occur during the clr cycle; clr overrides everything else.
  - Reset mid-stream: all state is cleared immediately; RAM contents are irrelevant.

Optional Feature:
DPRAM_FIFO_LEVEL_EN
- Defined: adds output port level, width ADDR_WIDTH+2, registered.
  - level = ram_cnt + rd_pend + ob_cnt, i.e. total words held; range 0..DEPTH+2.
  - Reset and clr both give 0.
  - Updated every cycle to reflect post-edge state.
- Not defined: no level port and no level logic; all other behaviour is identical.

Test Plan:
- ADDR_WIDTH=2 (DEPTH=4), out_ready=0, push 0x11..0x16 on consecutive cycles: all 6 accepted. in_ready drops after the 6th; 0x17 is held off. out_data=0x11; level=6.
- Same fill, then out_ready=1 continuously: out_data 0x11,0x12,...,0x16 on consecutive cycles. in_ready rises the cycle after the first RAM issue frees space.
- Empty controller, single push 0xA5 at cycle 10, out_ready=1: out_valid first high at cycle 13 with 0xA5, low at 14.
- Streaming 40 words (0x00..0x27) with in_valid=1 and out_ready toggling 1,1,0: output sequence in order with no loss or duplication. Pointers wrap several times.
- Fill to 6, assert clr one cycle with rd_pend=1: next cycle out_valid 0, in_ready 1, level 0. A subsequent push 0x3C emerges as the first word.
- rst_n pulsed low asynchronously mid-stream (between edges): out_valid and ram_we1 go 0 immediately. After release, the first push 0x77 emerges after 3 cycles.
